// File: rtl/proj_param_pkg.sv
// -----------------------------------------------------------------------------
// proj_param_pkg
// Project-wide parameters that are shared by several blocks.
// PROJ_GPIO : maximum GPIO pin count per bank across the project (1..64).
// -----------------------------------------------------------------------------
package proj_param_pkg;

    localparam int unsigned PROJ_GPIO = 32;

endpackage

// File: rtl/verilab_chip_gpio_pkg.sv
// -----------------------------------------------------------------------------
// verilab_chip_gpio_pkg
// Shared definitions for the GPIO bank controller: register word addresses,
// address width and the default pin count of a bank.
// -----------------------------------------------------------------------------
package verilab_chip_gpio_pkg;

    localparam int unsigned GPIO_DEFAULT = proj_param_pkg::PROJ_GPIO;
    localparam int unsigned REG_ADDR_W   = 4;

    typedef enum logic [REG_ADDR_W-1:0] {
        REG_DATA_OUT   = 4'd0,
        REG_DIR        = 4'd1,
        REG_DATA_IN    = 4'd2,
        REG_IRQ_EN     = 4'd3,
        REG_IRQ_RISE   = 4'd4,
        REG_IRQ_FALL   = 4'd5,
        REG_IRQ_STATUS = 4'd6,
        REG_DB_LIMIT   = 4'd7
    } gpio_reg_e;

endpackage

// File: rtl/verilab_chip_gpio_sync_db.sv
// -----------------------------------------------------------------------------
// verilab_chip_gpio_sync_db
// One pin's input conditioning: SYNC_STAGES-deep synchroniser followed, when
// GPIO_DEBOUNCE_EN is defined, by a saturating debounce counter.
// Ports:
//   clk_i, rst_i  bank clock, asynchronous active-high reset
//   pin_i         asynchronous pad input
//   db_limit_i    debounce limit (GPIO_DEBOUNCE_EN only); 0 = pass-through
//   in_o          conditioned pin value
// -----------------------------------------------------------------------------
module verilab_chip_gpio_sync_db #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DB_W = 8
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pin_i,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DB_W-1:0] db_limit_i,
`endif
    output logic            in_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_val;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_W-1:0] cnt_q;
    logic            db_q;

    // db_q keeps tracking the synchronised value while the limit is 0 so a
    // later non-zero limit starts from a consistent state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (db_limit_i == '0) begin
            cnt_q <= '0;
            db_q  <= sync_val;
        end else if (sync_val == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == db_limit_i) begin
            cnt_q <= '0;
            db_q  <= sync_val;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + DB_W'(1);
        end
    end

    assign in_o = (db_limit_i == '0) ? sync_val : db_q;
`else
    assign in_o = sync_val;
`endif

endmodule

// File: rtl/verilab_chip_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// verilab_chip_gpio_ctrl
// GPIO bank controller: register file, per-pin input conditioning, edge
// detection, W1C interrupt status and a single registered level IRQ.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-pin debounce + DB_LIMIT reg).
// Ports:
//   clk_i, rst_i        bank clock, asynchronous active-high reset
//   reg_wr_i, reg_rd_i  single-cycle write / read strobes
//   reg_addr_i          word address
//   reg_wdata_i         write data
//   reg_rdata_o         read data, registered, valid with reg_rvalid_o
//   reg_rvalid_o        read response, one cycle after reg_rd_i
//   gpio_in_i           asynchronous pad inputs
//   gpio_out_o          pad output values
//   gpio_oe_o           pad output enables (1 = drive)
//   irq_o               registered |(IRQ_STATUS & IRQ_EN)
// -----------------------------------------------------------------------------
module verilab_chip_gpio_ctrl
    import verilab_chip_gpio_pkg::*;
#(
    parameter int GPIO        = GPIO_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_wr_i,
    input  logic                  reg_rd_i,
    input  logic [REG_ADDR_W-1:0] reg_addr_i,
    input  logic [GPIO-1:0]       reg_wdata_i,
    output logic [GPIO-1:0]       reg_rdata_o,
    output logic                  reg_rvalid_o,
    input  logic [GPIO-1:0]       gpio_in_i,
    output logic [GPIO-1:0]       gpio_out_o,
    output logic [GPIO-1:0]       gpio_oe_o,
    output logic                  irq_o
);

    if (GPIO < 1 || GPIO > 64 || SYNC_STAGES < 2 || DB_W < 1) begin : g_param_chk
        $error("verilab_chip_gpio_ctrl: illegal parameter value");
    end

    logic [GPIO-1:0] data_out_q, data_out_d;
    logic [GPIO-1:0] dir_q, dir_d;
    logic [GPIO-1:0] irq_en_q, irq_en_d;
    logic [GPIO-1:0] irq_rise_q, irq_rise_d;
    logic [GPIO-1:0] irq_fall_q, irq_fall_d;
    logic [GPIO-1:0] irq_status_q, irq_status_d;
    logic [GPIO-1:0] in_prev_q;
    logic [GPIO-1:0] rdata_q, rdata_d;
    logic            rvalid_q;
    logic            irq_q, irq_d;

    logic [GPIO-1:0] in_q;
    logic [GPIO-1:0] pin_event;
    logic [GPIO-1:0] clr_mask;
    logic [GPIO-1:0] rd_mux;

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_W-1:0] db_limit_q, db_limit_d;
    logic [DB_W+GPIO-1:0] db_wr_ext;
    logic [DB_W+GPIO-1:0] db_rd_ext;

    // Zero-extend both ways so any GPIO/DB_W ratio slices cleanly.
    assign db_wr_ext = {{DB_W{1'b0}}, reg_wdata_i};
    assign db_rd_ext = {{GPIO{1'b0}}, db_limit_q};
`endif

    for (genvar i = 0; i < GPIO; i++) begin : g_pin
`ifdef GPIO_DEBOUNCE_EN
        verilab_chip_gpio_sync_db #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_sync_db (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .pin_i      (gpio_in_i[i]),
            .db_limit_i (db_limit_q),
            .in_o       (in_q[i])
        );
`else
        verilab_chip_gpio_sync_db #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_db (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .pin_i (gpio_in_i[i]),
            .in_o  (in_q[i])
        );
`endif
    end

    assign pin_event = (in_q & ~in_prev_q & irq_rise_q) | (~in_q & in_prev_q & irq_fall_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_rise_d = irq_rise_q;
        irq_fall_d = irq_fall_q;
        clr_mask   = '0;
`ifdef GPIO_DEBOUNCE_EN
        db_limit_d = db_limit_q;
`endif
        if (reg_wr_i) begin
            case (reg_addr_i)
                REG_DATA_OUT:   data_out_d = reg_wdata_i;
                REG_DIR:        dir_d      = reg_wdata_i;
                REG_IRQ_EN:     irq_en_d   = reg_wdata_i;
                REG_IRQ_RISE:   irq_rise_d = reg_wdata_i;
                REG_IRQ_FALL:   irq_fall_d = reg_wdata_i;
                REG_IRQ_STATUS: clr_mask   = reg_wdata_i;
`ifdef GPIO_DEBOUNCE_EN
                REG_DB_LIMIT:   db_limit_d = db_wr_ext[DB_W-1:0];
`endif
                default: ;
            endcase
        end
        // A fresh event overrides a clear landing in the same cycle.
        irq_status_d = (irq_status_q & ~clr_mask) | pin_event;
        irq_d        = |(irq_status_q & irq_en_q);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            REG_DATA_OUT:   rd_mux = data_out_q;
            REG_DIR:        rd_mux = dir_q;
            REG_DATA_IN:    rd_mux = in_q;
            REG_IRQ_EN:     rd_mux = irq_en_q;
            REG_IRQ_RISE:   rd_mux = irq_rise_q;
            REG_IRQ_FALL:   rd_mux = irq_fall_q;
            REG_IRQ_STATUS: rd_mux = irq_status_q;
`ifdef GPIO_DEBOUNCE_EN
            REG_DB_LIMIT:   rd_mux = db_rd_ext[GPIO-1:0];
`endif
            default:        rd_mux = '0;
        endcase
        rdata_d = reg_rd_i ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_rise_q   <= '0;
            irq_fall_q   <= '0;
            irq_status_q <= '0;
            in_prev_q    <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            irq_q        <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            db_limit_q   <= '0;
`endif
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_rise_q   <= irq_rise_d;
            irq_fall_q   <= irq_fall_d;
            irq_status_q <= irq_status_d;
            in_prev_q    <= in_q;
            rdata_q      <= rdata_d;
            rvalid_q     <= reg_rd_i;
            irq_q        <= irq_d;
`ifdef GPIO_DEBOUNCE_EN
            db_limit_q   <= db_limit_d;
`endif
        end
    end

    assign gpio_out_o   = data_out_q;
    assign gpio_oe_o    = dir_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_verilab_chip_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_verilab_chip_gpio_ctrl
// Directed bench for the GPIO bank controller (32-pin instance).
// -----------------------------------------------------------------------------
module tb_verilab_chip_gpio_ctrl;
    import verilab_chip_gpio_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          reg_wr;
    logic          reg_rd;
    logic [3:0]    reg_addr;
    logic [W-1:0]  reg_wdata;
    logic [W-1:0]  reg_rdata;
    logic          reg_rvalid;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    verilab_chip_gpio_ctrl #(
        .GPIO        (W),
        .SYNC_STAGES (2),
        .DB_W        (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_wr_i     (reg_wr),
        .reg_rd_i     (reg_rd),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_rdata_o  (reg_rdata),
        .reg_rvalid_o (reg_rvalid),
        .gpio_in_i    (gpio_in),
        .gpio_out_o   (gpio_out),
        .gpio_oe_o    (gpio_oe),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [W-1:0] data);
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [W-1:0] exp, input string tag);
        reg_rd   = 1'b1;
        reg_addr = addr;
        tick();
        reg_rd   = 1'b0;
        chk({tag, "_rvalid"}, 64'(reg_rvalid), 64'd1);
        chk(tag, 64'(reg_rdata), 64'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        gpio_in   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_gpio_oe", 64'(gpio_oe), 64'd0);
        chk("rst_gpio_out", 64'(gpio_out), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_rvalid", 64'(reg_rvalid), 64'd0);
        chk("rst_rdata", 64'(reg_rdata), 64'd0);
        for (int a = 0; a < 8; a++) begin
            rd_chk(4'(a), '0, $sformatf("rst_rd%0d", a));
        end
        tick();
        chk("rvalid_drop", 64'(reg_rvalid), 64'd0);

        // Direction and output drive
        wr(4'd1, 32'h0000_00FF);
        chk("dir_oe", 64'(gpio_oe), 64'hFF);
        wr(4'd0, 32'h0000_00A5);
        chk("dout_out", 64'(gpio_out), 64'hA5);
        chk("dout_oe", 64'(gpio_oe), 64'hFF);
        rd_chk(4'd0, 32'hA5, "rd_dout");
        rd_chk(4'd1, 32'hFF, "rd_dir");

        // Input sampling
        gpio_in = 32'h0000_0101;
        tick(); tick(); tick();
        rd_chk(4'd2, 32'h0000_0101, "rd_din");

        // Rise on pin 3: status after SYNC_STAGES+1 edges, irq one edge later
        wr(4'd4, 32'h8);
        wr(4'd3, 32'h8);
        gpio_in[3] = 1'b1;
        tick(); tick();
        rd_chk(4'd6, 32'h0, "sts_early");
        chk("irq_early", 64'(irq), 64'd0);
        rd_chk(4'd6, 32'h8, "sts_rise");
        chk("irq_rise", 64'(irq), 64'd1);
        rd_chk(4'd2, 32'h0000_0109, "rd_din_p3");

        // Fall on pin 3 is not enabled: no new event
        gpio_in[3] = 1'b0;
        tick(); tick(); tick(); tick();
        rd_chk(4'd6, 32'h8, "sts_nofall");

        // Clear in the same cycle as a new rise: event wins
        gpio_in[3] = 1'b1;
        tick(); tick();
        wr(4'd6, 32'h8);
        chk("irq_clr_vs_set", 64'(irq), 64'd1);
        rd_chk(4'd6, 32'h8, "sts_clr_vs_set");
        chk("irq_clr_vs_set2", 64'(irq), 64'd1);

        // Plain W1C clear, irq follows one edge later
        wr(4'd6, 32'h8);
        chk("irq_clr_lag", 64'(irq), 64'd1);
        rd_chk(4'd6, 32'h0, "sts_clr");
        chk("irq_clr", 64'(irq), 64'd0);

        // Fall on pin 0 with IRQ_EN clear: status sets, irq stays low
        wr(4'd3, 32'h0);
        wr(4'd5, 32'h1);
        gpio_in[0] = 1'b0;
        tick(); tick(); tick(); tick();
        rd_chk(4'd6, 32'h1, "sts_fall");
        chk("irq_masked", 64'(irq), 64'd0);
        wr(4'd3, 32'h1);
        chk("irq_en_lag", 64'(irq), 64'd0);
        tick();
        chk("irq_en", 64'(irq), 64'd1);

        // Simultaneous read and write to the same address returns old value
        reg_rd    = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = 4'd0;
        reg_wdata = 32'h0000_005A;
        tick();
        reg_rd = 1'b0;
        reg_wr = 1'b0;
        chk("rdwr_rvalid", 64'(reg_rvalid), 64'd1);
        chk("rdwr_old", 64'(reg_rdata), 64'hA5);
        chk("rdwr_out", 64'(gpio_out), 64'h5A);
        rd_chk(4'd0, 32'h5A, "rdwr_new");

        // Read-only register ignores writes
        wr(4'd2, 32'hFFFF_FFFF);
        rd_chk(4'd2, 32'h0000_0108, "ro_din");

`ifdef GPIO_DEBOUNCE_EN
        wr(4'd7, 32'h0000_01FF);
        rd_chk(4'd7, 32'h0000_00FF, "db_limit_rd");
        wr(4'd7, 32'h4);
        gpio_in[5] = 1'b1;
        tick(); tick();
        gpio_in[5] = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        rd_chk(4'd2, 32'h0000_0108, "db_glitch");
        gpio_in[5] = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();
        gpio_in[5] = 1'b0;
        tick();
        rd_chk(4'd2, 32'h0000_0128, "db_pulse");
`else
        wr(4'd7, 32'h0000_00FF);
        rd_chk(4'd7, 32'h0, "unmapped7");
`endif
        rd_chk(4'd9, 32'h0, "unmapped9");

        // rdata holds while rvalid is low
        rd_chk(4'd1, 32'hFF, "hold_rd");
        tick();
        chk("hold_rvalid", 64'(reg_rvalid), 64'd0);
        chk("hold_rdata", 64'(reg_rdata), 64'hFF);

        // Asynchronous reset in the middle of back-to-back reads
        reg_rd   = 1'b1;
        reg_addr = 4'd1;
        tick();
        chk("pre_rst_rvalid", 64'(reg_rvalid), 64'd1);
        chk("pre_rst_irq", 64'(irq), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(reg_rvalid), 64'd0);
        chk("mid_rst_rdata", 64'(reg_rdata), 64'd0);
        chk("mid_rst_irq", 64'(irq), 64'd0);
        chk("mid_rst_oe", 64'(gpio_oe), 64'd0);
        chk("mid_rst_out", 64'(gpio_out), 64'd0);
        reg_rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_rvalid", 64'(reg_rvalid), 64'd0);
        rd_chk(4'd6, 32'h0, "post_rst_sts");
        rd_chk(4'd3, 32'h0, "post_rst_en");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
